bht_update_controller: RTL and testbench
========================================

Name: bht_update_controller

Overview:
- Owns a table of 2^INDEX_BITS two-bit saturating branch counters (00 SNT, 01 WNT, 10 WT, 11 ST).
- Shares the table between two requesters: the fetch-stage lookup port and the execute-stage resolved-branch update port.
- Sequences table initialisation after reset or flush.
- Buffers updates in a small FIFO and applies them with a two-cycle read-modify-write sequencer, so fetch lookups are never stalled by updates.

Parameters:
- INDEX_BITS, 4, table index width; the table has 2^INDEX_BITS entries.
- QDEPTH, 2, update FIFO depth in entries (power of two, ≥2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous pulse; restarts initialisation.
- lookup_valid  input  1  fetch requests a prediction this cycle.
- lookup_pc  input  32  fetch PC.
- pred_valid  output  1  pred_taken/pred_state are valid (registered).
- pred_taken  output  1  predicted direction, equal to pred_state[1].
- pred_state  output  2  counter value for the looked-up entry.
- upd_valid  input  1  a resolved branch is presented.
- upd_pc  input  32  PC of the resolved branch.
- upd_taken  input  1  actual outcome of the resolved branch.
- upd_ready  output  1  FIFO can accept an update; a transfer occurs when upd_valid && upd_ready.
- init_busy  output  1  initialisation is in progress.

Behaviour:
- Index for both ports is pc[INDEX_BITS+1:2]. PC bits [1:0] are ignored.
- Reset (asynchronous):
  - FSM goes to INIT; init pointer = 0; FIFO empty.
  - pred_valid = 0, pred_taken = 0, pred_state = 00.
  - upd_ready = 0, init_busy = 1.
  - Table contents are don't-care until INIT completes.
- FSM states:
  - INIT: write 00 to entry[init_ptr], then init_ptr++ each cycle. After the last entry is written, go to IDLE. INIT lasts exactly 2^INDEX_BITS cycles. init_busy = 1 and upd_ready = 0 throughout.
  - IDLE: if the FIFO is non-empty, go to UPD_RD.
  - UPD_RD: read entry[head index] into a holding register; go to UPD_WR.
  - UPD_WR: write the saturated next value and pop the FIFO. Go to UPD_RD if the FIFO is still non-empty, otherwise to IDLE.
- Saturation on write:
  - If taken and value ≠ 11: value + 1.
  - If not taken and value ≠ 00: value − 1.
  - Otherwise the value is unchanged. No wrap 11→00 or 00→11.
- Update drain throughput is one update per two cycles.
- Update FIFO:
  - upd_ready = !full && !init_busy.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Order is strictly FIFO, including back-to-back updates to the same index: the second read happens after the first write.
- Lookup timing:
  - Registered, 1-cycle latency: pred_valid(t+1) = lookup_valid(t), and pred_state(t+1) = table value at t.
  - Lookups are accepted in every state.
- Lookup bypass: if, in the lookup cycle, the FSM is in UPD_WR for the same index, the lookup returns the newly written value. Queued-but-unapplied updates are not forwarded.
- Lookup during INIT: pred_valid follows lookup_valid; pred_state = 00 and pred_taken = 0 (static not-taken), regardless of table contents.
- flush (synchronous):
  - Takes priority over all other activity.
  - Empties the FIFO, discards any in-flight RMW without writing, zeroes init_ptr, enters INIT, and sets pred_valid = 0 on the next cycle.
  - An update presented in the flush cycle is dropped.
- Asserting reset at any point (mid-INIT or mid-RMW) yields the full reset state immediately.

Test Plan:
- Reset, then idle for 20 cycles (INDEX_BITS = 4) → init_busy high for exactly 16 cycles after reset release; upd_ready rises on cycle 17; a lookup of any PC returns pred_state = 00.
- Three taken updates to PC 0x40, then lookup 0x40 → 01, 10, 11 observed after each drain; a fourth taken update leaves 11 (no wrap). Three not-taken updates return the entry to 00, and a further not-taken stays at 00.
- Update back-to-back every cycle with QDEPTH = 2 → upd_ready drops when the FIFO holds 2 entries; no update is lost; the final counters match a reference model.
- Lookup PC 0x44 in the UPD_WR cycle of a taken update to 0x44 whose old value was 01 → pred_state = 10 on the next cycle.
- Two updates queued, with flush asserted during UPD_RD → no table write occurs, the FIFO is empty, and init_busy is high for 16 cycles; afterwards all entries read 00.
- Reset asserted mid-RMW on a 01→10 update → outputs clear immediately, INIT reruns, and the entry reads 00.

Source files
------------

// File: rtl/bht_update_controller.sv
// Two-bit saturating branch history table with an init sequencer,
// a small update FIFO and a two-cycle read-modify-write update path.
module bht_update_controller #(
  parameter int INDEX_BITS = 4,
  parameter int QDEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [1:0]  pred_state,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  output logic        upd_ready,
  output logic        init_busy
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int QW      = $clog2(QDEPTH);
  localparam logic [QW:0] QFULL = (QW+1)'(QDEPTH);

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_WR   = 2'd3;

  logic [1:0]            tbl_q [ENTRIES];
  logic [INDEX_BITS-1:0] q_idx_q [QDEPTH];
  logic                  q_tkn_q [QDEPTH];

  logic [1:0]            state_q, state_d;
  logic [INDEX_BITS-1:0] init_ptr_q, init_ptr_d;
  logic [1:0]            hold_q, hold_d;
  logic [QW-1:0]         wp_q, wp_d, rp_q, rp_d;
  logic [QW:0]           cnt_q, cnt_d;
  logic                  pv_q, pv_d;
  logic [1:0]            ps_q, ps_d;

  logic [INDEX_BITS-1:0] lkp_idx, upd_idx, head_idx, tbl_wa;
  logic                  head_tkn, push, pop, empty, full;
  logic                  tbl_we;
  logic [1:0]            wr_val, tbl_wd;
  logic                  unused_pc_bits;

  function automatic logic [1:0] sat2(input logic [1:0] v,
                                      input logic t);
    if (t) return (v == 2'b11) ? v : v + 2'd1;
    return (v == 2'b00) ? v : v - 2'd1;
  endfunction

  assign lkp_idx  = lookup_pc[INDEX_BITS+1:2];
  assign upd_idx  = upd_pc[INDEX_BITS+1:2];
  assign head_idx = q_idx_q[rp_q];
  assign head_tkn = q_tkn_q[rp_q];
  assign wr_val   = sat2(hold_q, head_tkn);

  assign unused_pc_bits = ^{lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0],
                            upd_pc[31:INDEX_BITS+2], upd_pc[1:0]};

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == QFULL);
  assign init_busy = (state_q == S_INIT);
  assign upd_ready = !full && !init_busy;

  // flush wins over everything: no push, no pop, no table write
  assign push = upd_valid && upd_ready && !flush;
  assign pop  = (state_q == S_WR) && !flush;

  assign tbl_we = !flush && (state_q == S_INIT || state_q == S_WR);
  assign tbl_wa = (state_q == S_INIT) ? init_ptr_q : head_idx;
  assign tbl_wd = (state_q == S_INIT) ? 2'b00 : wr_val;

  always_comb begin
    cnt_d = cnt_q + {{QW{1'b0}}, push} - {{QW{1'b0}}, pop};
    wp_d  = push ? wp_q + 1'b1 : wp_q;
    rp_d  = pop  ? rp_q + 1'b1 : rp_q;
    if (flush) begin
      cnt_d = '0;
      wp_d  = '0;
      rp_d  = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    hold_d     = hold_q;
    if (flush) begin
      state_d    = S_INIT;
      init_ptr_d = '0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          init_ptr_d = init_ptr_q + 1'b1;
          if (init_ptr_q == '1) state_d = S_IDLE;
        end
        S_IDLE: if (!empty) state_d = S_RD;
        S_RD: begin
          hold_d  = tbl_q[head_idx];
          state_d = S_WR;
        end
        S_WR: state_d = (cnt_d != '0) ? S_RD : S_IDLE;
        default: state_d = S_INIT;
      endcase
    end
  end

  // lookup forwards the value being written this cycle
  always_comb begin
    pv_d = lookup_valid && !flush;
    ps_d = ps_q;
    if (lookup_valid) begin
      if (state_q == S_INIT) ps_d = 2'b00;
      else if (state_q == S_WR && head_idx == lkp_idx) ps_d = wr_val;
      else ps_d = tbl_q[lkp_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      init_ptr_q <= '0;
      hold_q     <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      pv_q       <= 1'b0;
      ps_q       <= 2'b00;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      hold_q     <= hold_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cnt_q      <= cnt_d;
      pv_q       <= pv_d;
      ps_q       <= ps_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_we) tbl_q[tbl_wa] <= tbl_wd;
    if (push) begin
      q_idx_q[wp_q] <= upd_idx;
      q_tkn_q[wp_q] <= upd_taken;
    end
  end

  assign pred_valid = pv_q;
  assign pred_state = ps_q;
  assign pred_taken = ps_q[1];

endmodule

// File: tb/tb_bht_update_controller.sv
// Bench for bht_update_controller: vector table, hand-written corner
// sequences and randomized updates against an array-based model.
module tb_bht_update_controller;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        lookup_valid, upd_valid, upd_taken;
  logic [31:0] lookup_pc, upd_pc;
  logic        pred_valid, pred_taken, upd_ready, init_busy;
  logic [1:0]  pred_state;

  int total = 0;
  int bad   = 0;
  logic [1:0] mdl [16];

  always #5 clk = ~clk;

  bht_update_controller dut (
    .clk(clk), .reset(reset), .flush(flush),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_state(pred_state), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_ready(upd_ready), .init_busy(init_busy)
  );

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [1:0]  exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) & 32'hF);
  endfunction

  function automatic logic [1:0] next_ctr(input logic [1:0] v,
                                          input logic t);
    int n;
    n = t ? int'(v) + 1 : int'(v) - 1;
    if (n > 3) n = 3;
    if (n < 0) n = 0;
    return n[1:0];
  endfunction

  function automatic logic [31:0] pc_for(input int i);
    return ($urandom & ~32'h3C) | (32'(i) << 2);
  endfunction

  task automatic look(input logic [31:0] pc, input logic [1:0] exp,
                      input string nm);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    tick();
    lookup_valid = 1'b0;
    chk({nm, "_pv"}, 32'(pred_valid), 32'd1);
    chk(nm, 32'(pred_state), 32'(exp));
    chk({nm, "_pt"}, 32'(pred_taken), 32'(exp[1]));
  endtask

  task automatic send(input logic [31:0] pc, input logic t);
    int g = 0;
    while (!upd_ready && g < 50) begin
      tick();
      g++;
    end
    chk("send_ready", 32'(upd_ready), 32'd1);
    upd_valid = 1'b1;
    upd_pc    = pc;
    upd_taken = t;
    tick();
    upd_valid = 1'b0;
    mdl[idx_of(pc)] = next_ctr(mdl[idx_of(pc)], t);
  endtask

  task automatic count_init(input logic [31:0] pc, input string nm);
    int n = 0;
    while (init_busy && n < 40) begin
      n++;
      lookup_valid = 1'b1;
      lookup_pc    = pc;
      tick();
      chk({nm, "_init_pv"}, 32'(pred_valid), 32'd1);
      chk({nm, "_init_ps"}, 32'(pred_state), 32'd0);
    end
    lookup_valid = 1'b0;
    chk({nm, "_init_len"}, 32'(n), 32'd16);
    chk({nm, "_ready_after"}, 32'(upd_ready), 32'd1);
    for (int i = 0; i < 16; i++) mdl[i] = 2'b00;
  endtask

  task automatic check_all(input string nm);
    for (int i = 0; i < 16; i++) look(pc_for(i), mdl[i], nm);
  endtask

  vec_t vt[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0;
    lookup_valid = 1'b0; lookup_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = 2'b00;

    vt[0] = '{32'h40, 1'b1, 2'b01};
    vt[1] = '{32'h41, 1'b1, 2'b10};
    vt[2] = '{32'hC2, 1'b1, 2'b11};
    vt[3] = '{32'h43, 1'b1, 2'b11};
    vt[4] = '{32'h40, 1'b0, 2'b10};
    vt[5] = '{32'h140, 1'b0, 2'b01};
    vt[6] = '{32'h40, 1'b0, 2'b00};
    vt[7] = '{32'h40, 1'b0, 2'b00};

    tick();
    tick();
    chk("rst_pv", 32'(pred_valid), 32'd0);
    chk("rst_pt", 32'(pred_taken), 32'd0);
    chk("rst_ps", 32'(pred_state), 32'd0);
    chk("rst_ready", 32'(upd_ready), 32'd0);
    chk("rst_busy", 32'(init_busy), 32'd1);
    reset = 1'b0;
    count_init(32'h40, "boot");
    repeat (3) tick();
    look(32'h1234_5678, 2'b00, "boot_look");

    // saturating counter walk on one entry
    foreach (vt[i]) begin
      send(vt[i].pc, vt[i].taken);
      repeat (4) tick();
      look(32'h40, vt[i].exp, $sformatf("vec%0d", i));
    end

    // bypass: lookup in the write cycle of a 01->10 update
    send(32'h44, 1'b1);
    repeat (4) tick();
    send(32'h44, 1'b1);
    tick();
    tick();
    look(32'h44, 2'b10, "bypass");
    repeat (4) tick();
    look(32'h44, 2'b10, "bypass_after");

    // back-to-back updates every cycle
    begin
      int acc = 0, cyc = 0;
      logic seen_low = 1'b0;
      logic a;
      logic [31:0] pcs [6];
      logic tk [6];
      for (int k = 0; k < 6; k++) begin
        pcs[k] = 32'h48 + 32'((k % 3) * 4);
        tk[k]  = (k != 4);
      end
      upd_valid = 1'b1;
      while (acc < 6 && cyc < 100) begin
        upd_pc    = pcs[acc];
        upd_taken = tk[acc];
        a = upd_ready;
        if (!upd_ready) seen_low = 1'b1;
        tick();
        cyc++;
        if (a) begin
          mdl[idx_of(pcs[acc])] = next_ctr(mdl[idx_of(pcs[acc])], tk[acc]);
          acc++;
          if (acc == 2) chk("b2b_full", 32'(upd_ready), 32'd0);
        end
      end
      upd_valid = 1'b0;
      chk("b2b_accepted", 32'(acc), 32'd6);
      chk("b2b_ready_low", 32'(seen_low), 32'd1);
      repeat (10) tick();
      check_all("b2b");
    end

    // randomized bursts against the model
    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(1, 8);
      int sent = 0, g = 0;
      logic a, lv;
      logic [31:0] p;
      logic t;
      while (sent < n && g < 200) begin
        lv = 1'(($urandom % 2));
        lookup_valid = lv;
        lookup_pc    = $urandom;
        p = $urandom;
        t = 1'(($urandom % 2));
        upd_valid = ($urandom % 4) != 0;
        upd_pc    = p;
        upd_taken = t;
        a = upd_valid && upd_ready;
        tick();
        g++;
        chk("rand_pv", 32'(pred_valid), 32'(lv));
        if (a) begin
          mdl[idx_of(p)] = next_ctr(mdl[idx_of(p)], t);
          sent++;
        end
      end
      upd_valid = 1'b0;
      lookup_valid = 1'b0;
      chk("rand_sent", 32'(sent), 32'(n));
      repeat (12) tick();
      check_all($sformatf("rand%0d", r));
    end

    // flush while an RMW is in its read cycle with two queued
    send(32'h4C, 1'b1);
    send(32'h4C, 1'b1);
    flush = 1'b1;
    lookup_valid = 1'b1;
    lookup_pc = 32'h4C;
    tick();
    flush = 1'b0;
    lookup_valid = 1'b0;
    chk("flush_pv", 32'(pred_valid), 32'd0);
    chk("flush_busy", 32'(init_busy), 32'd1);
    chk("flush_ready", 32'(upd_ready), 32'd0);
    count_init(32'h40, "flush");
    repeat (8) tick();
    check_all("flush_tbl");

    // update presented in the flush cycle is dropped
    repeat (2) tick();
    flush = 1'b1;
    upd_valid = 1'b1;
    upd_pc = 32'h50;
    upd_taken = 1'b1;
    tick();
    flush = 1'b0;
    upd_valid = 1'b0;
    count_init(32'h50, "flush2");
    repeat (6) tick();
    look(32'h50, 2'b00, "flush2_drop");

    // reset in the write cycle of a 01->10 update
    send(32'h50, 1'b1);
    repeat (4) tick();
    look(32'h50, 2'b01, "pre_rst");
    send(32'h50, 1'b1);
    lookup_valid = 1'b1;
    lookup_pc = 32'h54;
    tick();
    tick();
    lookup_valid = 1'b0;
    chk("pre_rst_pv", 32'(pred_valid), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_pv", 32'(pred_valid), 32'd0);
    chk("mid_rst_ps", 32'(pred_state), 32'd0);
    chk("mid_rst_ready", 32'(upd_ready), 32'd0);
    chk("mid_rst_busy", 32'(init_busy), 32'd1);
    #2;
    reset = 1'b0;
    count_init(32'h50, "rst2");
    repeat (6) tick();
    look(32'h50, 2'b00, "rst2_entry");
    check_all("rst2_tbl");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
